// File: rtl/retire_stage_pkg.sv
// Shared types for the retire stage: ROB packet, freelist return packet and the
// architectural map container.
package retire_stage_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PR_W      = 6;
    localparam int XLEN      = 32;
    localparam int AR_W      = $clog2(ARCH_REGS);
    localparam int RETIRE_W  = 3;
    localparam int CNT_W     = 32;

    typedef struct packed {
        logic             valid;
        logic [PR_W-1:0]  Tnew;
        logic [PR_W-1:0]  Told;
        logic [AR_W-1:0]  arch_reg;
        logic             has_dest;
        logic             precise_state_need;
        logic [XLEN-1:0]  target_pc;
        logic             is_store;
        logic             halt;
    } ROB_ENTRY_PACKET;

    typedef struct packed {
        logic             valid;
        logic [PR_W-1:0]  tag;
    } RETIRE_FREE_PACKET;

    typedef logic [ARCH_REGS-1:0][PR_W-1:0] ARCH_MAP;

endpackage

// File: rtl/retire_stage_if.sv
// Retire-stage bus: ROB packets in, commit side effects out.
interface retire_stage_if;
    import retire_stage_pkg::*;

    ROB_ENTRY_PACKET [RETIRE_W-1:0]           retire_entry;
    ARCH_MAP                                  archmap_out;
    logic            [RETIRE_W-1:0]           fl_free_valid;
    logic            [RETIRE_W-1:0][PR_W-1:0] fl_free_tag;
    logic            [RETIRE_W-1:0]           store_retire;
    logic                                     BPRecoverEN;
    logic            [XLEN-1:0]               recover_pc;
    logic                                     halt;
    logic            [CNT_W-1:0]              retired_count;

    modport master (
        output retire_entry,
        input  archmap_out, fl_free_valid, fl_free_tag, store_retire,
        input  BPRecoverEN, recover_pc, halt, retired_count
    );

    modport slave (
        input  retire_entry,
        output archmap_out, fl_free_valid, fl_free_tag, store_retire,
        output BPRecoverEN, recover_pc, halt, retired_count
    );

endinterface

// File: rtl/retire_stage_select.sv
// Oldest-first commit mask: slot 2 is oldest; the first committing slot that
// needs precise state or halts truncates every younger slot.
module retire_select
    import retire_stage_pkg::*;
(
    input  logic                i_enable,
    input  logic [RETIRE_W-1:0] i_valid,
    input  logic [RETIRE_W-1:0] i_psn,
    input  logic [RETIRE_W-1:0] i_halt,
    output logic [RETIRE_W-1:0] o_commit,
    output logic                o_recover,
    output logic [1:0]          o_recover_slot,
    output logic                o_halt
);

    logic w_alive;

    always_comb begin
        o_commit       = '0;
        o_recover      = 1'b0;
        o_recover_slot = '0;
        o_halt         = 1'b0;
        w_alive        = i_enable;
        for (int s = RETIRE_W - 1; s >= 0; s--) begin
            if (w_alive && i_valid[s]) begin
                o_commit[s] = 1'b1;
                if (i_psn[s]) begin
                    o_recover      = 1'b1;
                    o_recover_slot = 2'(s);
                end
                if (i_halt[s]) begin
                    o_halt = 1'b1;
                end
                // A redirecting or halting slot is the last one to commit this cycle.
                if (i_psn[s] || i_halt[s]) begin
                    w_alive = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/retire_stage.sv
// Commit stage: updates the architectural map, frees superseded tags, releases
// stores, counts retirements and raises recovery / halt.
module retire_stage
    import retire_stage_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    retire_stage_if.slave  rif
);

    logic                                w_enable;
    logic [RETIRE_W-1:0]                 w_valid;
    logic [RETIRE_W-1:0]                 w_psn;
    logic [RETIRE_W-1:0]                 w_halt_req;
    logic [RETIRE_W-1:0]                 w_commit;
    logic                                w_recover;
    logic [1:0]                          w_recover_slot;
    logic                                w_halt_hit;
    logic [XLEN-1:0]                     w_recover_pc;
    ARCH_MAP                             w_next_map;
    RETIRE_FREE_PACKET [RETIRE_W-1:0]    w_free;
    logic [RETIRE_W-1:0]                 w_store;
    logic [1:0]                          w_inc;

    ARCH_MAP                             r_archmap;
    RETIRE_FREE_PACKET [RETIRE_W-1:0]    r_free;
    logic [RETIRE_W-1:0]                 r_store;
    logic                                r_bp_recover;
    logic [XLEN-1:0]                     r_recover_pc;
    logic                                r_halt;
    logic [CNT_W-1:0]                    r_count;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // The squash cycle still shows wrong-path packets, and halt freezes everything.
    assign w_enable = !r_halt && !r_bp_recover;

    always_comb begin
        for (int s = 0; s < RETIRE_W; s++) begin
            w_valid[s]    = rif.retire_entry[s].valid;
            w_psn[s]      = rif.retire_entry[s].precise_state_need;
            w_halt_req[s] = rif.retire_entry[s].halt;
        end
    end

    retire_select u_select (
        .i_enable       (w_enable),
        .i_valid        (w_valid),
        .i_psn          (w_psn),
        .i_halt         (w_halt_req),
        .o_commit       (w_commit),
        .o_recover      (w_recover),
        .o_recover_slot (w_recover_slot),
        .o_halt         (w_halt_hit)
    );

    // Walk oldest to youngest so the youngest writer of a register lands last.
    always_comb begin
        w_next_map   = r_archmap;
        w_free       = '0;
        w_store      = '0;
        w_recover_pc = '0;
        for (int s = RETIRE_W - 1; s >= 0; s--) begin
            if (w_commit[s] && rif.retire_entry[s].has_dest &&
                rif.retire_entry[s].arch_reg != '0) begin
                w_next_map[rif.retire_entry[s].arch_reg] = rif.retire_entry[s].Tnew;
                w_free[s].valid = 1'b1;
                w_free[s].tag   = rif.retire_entry[s].Told;
            end
            w_store[s] = w_commit[s] && rif.retire_entry[s].is_store;
            if (w_recover && (w_recover_slot == 2'(s))) begin
                w_recover_pc = rif.retire_entry[s].target_pc;
            end
        end
    end

    assign w_inc = 2'($countones(w_commit));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_archmap[i] <= PR_W'(i);
            end
            r_free       <= '0;
            r_store      <= '0;
            r_bp_recover <= 1'b0;
            r_recover_pc <= '0;
            r_halt       <= 1'b0;
            r_count      <= '0;
        end else begin
            r_archmap    <= w_next_map;
            r_free       <= w_free;
            r_store      <= w_store;
            r_bp_recover <= w_recover;
            if (w_recover) begin
                r_recover_pc <= w_recover_pc;
            end
            r_halt       <= r_halt || w_halt_hit;
            r_count      <= sat_add(r_count, w_inc);
        end
    end

    always_comb begin
        for (int s = 0; s < RETIRE_W; s++) begin
            rif.fl_free_valid[s] = r_free[s].valid;
            rif.fl_free_tag[s]   = r_free[s].tag;
        end
    end

    assign rif.archmap_out   = r_archmap;
    assign rif.store_retire  = r_store;
    assign rif.BPRecoverEN   = r_bp_recover;
    assign rif.recover_pc    = r_recover_pc;
    assign rif.halt          = r_halt;
    assign rif.retired_count = r_count;

endmodule

// File: tb/tb_retire_stage.sv
// Randomized and directed checks of retire_stage against a rule-level model.
module tb_retire_stage;
    import retire_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    retire_stage_if rif ();

    retire_stage dut (
        .clock (clk),
        .reset (rst),
        .rif   (rif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [PR_W-1:0] m_map [ARCH_REGS];
    logic [31:0]     m_cnt;
    logic            m_halt;
    logic            m_bp;
    logic [XLEN-1:0] m_pc;
    logic [2:0]      m_fv;
    logic [2:0]      m_st;
    logic [PR_W-1:0] m_ft [3];

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ROB_ENTRY_PACKET mk(input logic v, input int tnew, input int told,
                                           input int arch, input logic dest, input logic psn,
                                           input logic [XLEN-1:0] pc, input logic st,
                                           input logic hlt);
        ROB_ENTRY_PACKET p;
        p.valid              = v;
        p.Tnew               = PR_W'(tnew);
        p.Told               = PR_W'(told);
        p.arch_reg           = AR_W'(arch);
        p.has_dest           = dest;
        p.precise_state_need = psn;
        p.target_pc          = pc;
        p.is_store           = st;
        p.halt               = hlt;
        return p;
    endfunction

    function automatic ROB_ENTRY_PACKET rnd_pkt(input int psn_div, input int halt_div);
        return mk(($urandom % 4) != 0, int'($urandom % 64), int'($urandom % 64),
                  int'($urandom % 32), ($urandom % 4) != 0,
                  (psn_div > 0) && (($urandom % psn_div) == 0), $urandom,
                  ($urandom % 3) == 0, (halt_div > 0) && (($urandom % halt_div) == 0));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ARCH_REGS; i++) m_map[i] = PR_W'(i);
        m_cnt = 0; m_halt = 0; m_bp = 0; m_pc = 0; m_fv = 0; m_st = 0;
        for (int s = 0; s < 3; s++) m_ft[s] = 0;
    endtask

    // Applies the commit rules for one sampled cycle.
    task automatic model_step(input ROB_ENTRY_PACKET [2:0] p);
        bit stop;
        int n;
        bit new_bp;
        m_fv = 0;
        m_st = 0;
        for (int s = 0; s < 3; s++) m_ft[s] = 0;
        if (m_halt || m_bp) begin
            m_bp = 0;
            return;
        end
        stop = 0; n = 0; new_bp = 0;
        for (int s = 2; s >= 0; s--) begin
            if (!stop && p[s].valid) begin
                n++;
                if (p[s].has_dest && p[s].arch_reg != 0) begin
                    m_map[p[s].arch_reg] = p[s].Tnew;
                    m_fv[s] = 1;
                    m_ft[s] = p[s].Told;
                end
                if (p[s].is_store) m_st[s] = 1;
                if (p[s].precise_state_need) begin
                    new_bp = 1;
                    m_pc = p[s].target_pc;
                end
                if (p[s].halt) m_halt = 1;
                if (p[s].precise_state_need || p[s].halt) stop = 1;
            end
        end
        if (m_cnt > 32'hFFFF_FFFF - 32'(n)) m_cnt = 32'hFFFF_FFFF;
        else m_cnt = m_cnt + 32'(n);
        m_bp = new_bp;
    endtask

    task automatic check_all(input string ctx);
        logic [191:0] em;
        em = '0;
        for (int i = 0; i < ARCH_REGS; i++) em[i*PR_W +: PR_W] = m_map[i];
        chk({ctx, ".map"},   192'(rif.archmap_out), em);
        chk({ctx, ".fv"},    192'(rif.fl_free_valid), 192'(m_fv));
        chk({ctx, ".st"},    192'(rif.store_retire), 192'(m_st));
        chk({ctx, ".bp"},    192'(rif.BPRecoverEN), 192'(m_bp));
        chk({ctx, ".pc"},    192'(rif.recover_pc), 192'(m_pc));
        chk({ctx, ".halt"},  192'(rif.halt), 192'(m_halt));
        chk({ctx, ".cnt"},   192'(rif.retired_count), 192'(m_cnt));
        for (int s = 0; s < 3; s++)
            if (m_fv[s]) chk($sformatf("%s.tag%0d", ctx, s), 192'(rif.fl_free_tag[s]), 192'(m_ft[s]));
    endtask

    task automatic do_reset(input string ctx);
        rst = 1'b1;
        rif.retire_entry = '0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_all(ctx);
        rst = 1'b0;
    endtask

    task automatic step(input ROB_ENTRY_PACKET [2:0] p, input string ctx);
        rif.retire_entry = p;
        @(posedge clk);
        model_step(p);
        @(negedge clk);
        check_all(ctx);
    endtask

    ROB_ENTRY_PACKET [2:0] pk;
    ROB_ENTRY_PACKET       z;

    initial begin
        z = '0;
        rst = 1'b1;
        rif.retire_entry = '0;
        @(negedge clk);
        do_reset("reset");
        chk("rst.map5", 192'(rif.archmap_out[5]), 192'(5));

        pk = {mk(1, 40, 5, 5, 1, 0, 0, 0, 0), z, z};
        step(pk, "single");
        chk("single.map5", 192'(rif.archmap_out[5]), 192'(40));
        chk("single.fv", 192'(rif.fl_free_valid), 192'(3'b100));
        chk("single.tag2", 192'(rif.fl_free_tag[2]), 192'(5));
        chk("single.cnt", 192'(rif.retired_count), 192'(1));

        pk = {mk(1, 33, 10, 7, 1, 0, 0, 0, 0), mk(1, 34, 11, 7, 1, 0, 0, 0, 0),
              mk(1, 35, 12, 7, 1, 0, 0, 0, 0)};
        step(pk, "waw");
        chk("waw.map7", 192'(rif.archmap_out[7]), 192'(35));
        chk("waw.fv", 192'(rif.fl_free_valid), 192'(3'b111));
        chk("waw.cnt", 192'(rif.retired_count), 192'(4));

        pk = {mk(1, 0, 0, 0, 0, 0, 0, 1, 0), mk(1, 0, 0, 0, 0, 1, 32'h1000, 0, 0),
              mk(1, 0, 0, 0, 0, 0, 0, 1, 0)};
        step(pk, "mispred");
        chk("mispred.bp", 192'(rif.BPRecoverEN), 192'(1));
        chk("mispred.pc", 192'(rif.recover_pc), 192'(32'h1000));
        chk("mispred.st", 192'(rif.store_retire), 192'(3'b100));
        chk("mispred.cnt", 192'(rif.retired_count), 192'(6));

        pk = {mk(1, 50, 9, 9, 1, 0, 0, 1, 0), mk(1, 51, 8, 8, 1, 0, 0, 0, 0), z};
        step(pk, "squash");
        chk("squash.map9", 192'(rif.archmap_out[9]), 192'(9));
        chk("squash.cnt", 192'(rif.retired_count), 192'(6));
        chk("squash.bp", 192'(rif.BPRecoverEN), 192'(0));

        pk = {mk(1, 20, 3, 0, 1, 0, 0, 0, 0), z, z};
        step(pk, "x0");
        chk("x0.fv", 192'(rif.fl_free_valid), 192'(0));
        chk("x0.map0", 192'(rif.archmap_out[0]), 192'(0));
        chk("x0.cnt", 192'(rif.retired_count), 192'(7));

        for (int c = 0; c < 300; c++) begin
            pk = {rnd_pkt(8, 0), rnd_pkt(8, 0), rnd_pkt(8, 0)};
            step(pk, $sformatf("rnd%0d", c));
        end

        pk = {z, mk(1, 0, 0, 0, 0, 0, 0, 0, 1), mk(1, 50, 3, 3, 1, 0, 0, 1, 0)};
        step(pk, "halt");
        chk("halt.flag", 192'(rif.halt), 192'(1));
        chk("halt.fv", 192'(rif.fl_free_valid), 192'(0));
        chk("halt.st", 192'(rif.store_retire), 192'(0));
        for (int c = 0; c < 5; c++) begin
            pk = {rnd_pkt(4, 0), rnd_pkt(4, 0), rnd_pkt(4, 0)};
            step(pk, $sformatf("frozen%0d", c));
        end
        do_reset("halt.reset");
        chk("halt.reset.flag", 192'(rif.halt), 192'(0));
        chk("halt.reset.map3", 192'(rif.archmap_out[3]), 192'(3));

        pk = {mk(1, 44, 6, 6, 1, 1, 32'hBEEF0, 0, 0), z, z};
        step(pk, "midrec");
        chk("midrec.bp", 192'(rif.BPRecoverEN), 192'(1));
        do_reset("midrec.reset");
        chk("midrec.reset.map6", 192'(rif.archmap_out[6]), 192'(6));

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 60; c++) begin
                pk = {rnd_pkt(6, 40), rnd_pkt(6, 40), rnd_pkt(6, 40)};
                step(pk, $sformatf("mix%0d_%0d", r, c));
            end
            do_reset($sformatf("mixrst%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
